fifo_word_unpacker_reader: RTL and testbench
============================================

// Module: fifo_word_unpacker_reader
// PURPOSE
//  Read-side companion of the SRAM-backed byte FIFO. Pops bytes from the FIFO
//  output port, absorbing the SRAM's 1-cycle read latency. Packs BYTES_PER_WORD
//  consecutive bytes into one word and hands it to the accelerator datapath
//  over a valid/ready stream. Sustains 1 byte/cycle while the downstream is ready.
// PARAMETERS
//  BYTE_WIDTH      8  width of one FIFO entry (fifo_data)
//  BYTES_PER_WORD  4  bytes packed per output word; >=2
// PORTS
//  clk           in   1                    single clock, rising edge
//  arst_in       in   1                    asynchronous reset, active-high
//  fifo_valid    in   1                    FIFO not empty
//  fifo_ready    out  1                    pop request (FIFO read enable)
//  fifo_data     in   BYTE_WIDTH           SRAM read data, valid 1 cycle after a pop
//  word_out      out  BYTE_WIDTH*BPW       packed word (BPW = BYTES_PER_WORD)
//  word_valid    out  1                    word_out holds an unconsumed word
//  word_ready    in   1                    downstream accepts word_out
//  words_packed  out  16                   count of words delivered, wraps mod 2^16
// BEHAVIOUR
//  Reset: clk and arst_in are the only clock and reset. arst_in=1 asynchronously
//   clears fifo_ready=0 (combinational; forced 0 while in reset), word_valid=0,
//   word_out=0, words_packed=0, count=0, inflight=0, and the assembly register.
//   Reset mid-operation discards a popped-but-unlanded byte and any partial word.
//  pop = fifo_valid && fifo_ready; inflight <= pop (1-bit register).
//  Cycle t pop -> fifo_data is sampled at end of cycle t+1 (land). fifo_data is
//   ignored in all other cycles.
//  count = bytes held in the assembly register, range 0..BPW.
//  Lane order: the k-th landed byte of a word goes to bits
//   [k*BYTE_WIDTH +: BYTE_WIDTH]. The first byte popped is lane 0.
//  out_free = !word_valid || word_ready.
//  Land with count<BPW-1: store in lane count, count++.
//  Land with count==BPW-1 and out_free (direct transfer): word_out <= assembly
//   with this byte in lane BPW-1, word_valid<=1, count<=0.
//  Land with count==BPW-1 and !out_free: store the byte, count<=BPW (full).
//  count==BPW and out_free: word_out <= assembly, word_valid<=1, count<=0.
//   No landing can occur in this cycle; fifo_ready guarantees it.
//  Output handshake: word_valid && word_ready consumes the word; word_valid
//   drops unless a new word loads in the same cycle (back-to-back allowed).
//   word_out is stable while word_valid && !word_ready.
//  words_packed increments by 1 per word loaded into word_out.
//  fifo_ready = (count+inflight < BPW) ||
//   (count+inflight == BPW && inflight && count==BPW-1 && out_free).
//   This gives no overflow of the assembly register and no bubble when downstream
//   is ready. It depends combinationally on word_ready; no path from fifo_data.
//  FIFO empty (fifo_valid=0): no pop; a partial word is held indefinitely.
//  Simultaneous word consume and direct-transfer land: the new word replaces the
//   old one in the same cycle and word_valid stays 1.
//  Count arithmetic: count is $clog2(BPW+1) bits. count+inflight never exceeds BPW.
// TESTING
//  1 Reset: arst_in pulses high mid-cycle -> all outputs 0 immediately.
//    fifo_ready=0 while arst_in=1.
//  2 Streaming: BPW=4, FIFO holds 0x01..0x08, word_ready=1 ->
//    word_out=0x04030201, then 0x08070605. fifo_ready high 8 consecutive cycles.
//    words_packed=2.
//  3 Backpressure: word_ready=0 after first word -> second word assembles,
//    count=4, fifo_ready=0. word_out stays 0x04030201 until word_ready=1.
//    Then the next word 0x08070605 loads in one cycle with no lost or duplicated byte.
//  4 Sparse input: fifo_valid toggles every other cycle with bytes 0xA0..0xA3 ->
//    single word 0xA3A2A1A0. No pop while fifo_valid=0.
//  5 Reset mid-word: 2 bytes landed and 1 inflight, assert arst_in ->
//    after release, bytes 0x11..0x14 give word 0x14131211, with no stale lanes.
//  6 Random: random fifo_valid/word_ready for 10k bytes -> scoreboard shows the
//    output byte stream equals the input in order. words_packed equals bytes/4 mod 2^16.

Source files
------------

// File: rtl/fifo_word_unpacker_reader.sv
// Pops bytes from an SRAM-backed FIFO (1-cycle read latency) and packs
// BYTES_PER_WORD of them, lane 0 first, into words on a valid/ready stream.
module fifo_word_unpacker_reader #(
    parameter int BYTE_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                                 clk,
    input  logic                                 arst_in,
    input  logic                                 fifo_valid,
    output logic                                 fifo_ready,
    input  logic [BYTE_WIDTH-1:0]                fifo_data,
    output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] word_out,
    output logic                                 word_valid,
    input  logic                                 word_ready,
    output logic [15:0]                          words_packed
);

    localparam int BPW = BYTES_PER_WORD;
    localparam int WW  = BYTE_WIDTH * BPW;
    localparam int CW  = $clog2(BPW + 1);
    localparam int SW  = CW + 1;
    localparam logic [CW-1:0] LAST  = CW'(BPW - 1);
    localparam logic [CW-1:0] FULL  = CW'(BPW);
    localparam logic [SW-1:0] BPW_S = SW'(BPW);

    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [WW-1:0] asm_q, asm_d;
    logic [WW-1:0] word_q, word_d;
    logic          word_valid_q, word_valid_d;
    logic [15:0]   words_packed_q, words_packed_d;

    logic [SW-1:0] occupancy;
    logic          out_free;
    logic          ready_raw;
    logic          pop;

    always_comb begin
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        out_free  = !word_valid_q || word_ready;
        // The second term lets the last byte of a word be popped while the
        // previous landing hands its word straight to the output register.
        ready_raw = (occupancy < BPW_S) ||
                    ((occupancy == BPW_S) && inflight_q && (count_q == LAST) && out_free);
        fifo_ready = 1'b0;
        if (!arst_in) begin
            fifo_ready = ready_raw;
        end
        pop = fifo_valid && fifo_ready;
    end

    always_comb begin
        count_d        = count_q;
        inflight_d     = pop;
        asm_d          = asm_q;
        word_d         = word_q;
        word_valid_d   = word_valid_q && !word_ready;
        words_packed_d = words_packed_q;

        if (inflight_q) begin
            if (count_q < LAST) begin
                for (int k = 0; k < BPW; k++) begin
                    if (count_q == CW'(k)) begin
                        asm_d[k*BYTE_WIDTH +: BYTE_WIDTH] = fifo_data;
                    end
                end
                count_d = count_q + CW'(1);
            end else if (out_free) begin
                word_d = asm_q;
                word_d[(BPW-1)*BYTE_WIDTH +: BYTE_WIDTH] = fifo_data;
                word_valid_d   = 1'b1;
                count_d        = '0;
                words_packed_d = words_packed_q + 16'd1;
            end else begin
                asm_d[(BPW-1)*BYTE_WIDTH +: BYTE_WIDTH] = fifo_data;
                count_d = FULL;
            end
        end else if ((count_q == FULL) && out_free) begin
            word_d         = asm_q;
            word_valid_d   = 1'b1;
            count_d        = '0;
            words_packed_d = words_packed_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            count_q        <= '0;
            inflight_q     <= 1'b0;
            asm_q          <= '0;
            word_q         <= '0;
            word_valid_q   <= 1'b0;
            words_packed_q <= '0;
        end else begin
            count_q        <= count_d;
            inflight_q     <= inflight_d;
            asm_q          <= asm_d;
            word_q         <= word_d;
            word_valid_q   <= word_valid_d;
            words_packed_q <= words_packed_d;
        end
    end

    assign word_out     = word_q;
    assign word_valid   = word_valid_q;
    assign words_packed = words_packed_q;

endmodule

// File: tb/tb_fifo_word_unpacker_reader.sv
// Bench for fifo_word_unpacker_reader: FIFO/SRAM model, per-cycle vector table,
// byte-order scoreboard and hand-written reset / sparse / random sequences.
module tb_fifo_word_unpacker_reader;

    logic        clk;
    logic        arst_in;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [7:0]  fifo_data;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [15:0] words_packed;

    fifo_word_unpacker_reader #(.BYTE_WIDTH(8), .BYTES_PER_WORD(4)) dut (
        .clk          (clk),
        .arst_in      (arst_in),
        .fifo_valid   (fifo_valid),
        .fifo_ready   (fifo_ready),
        .fifo_data    (fifo_data),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .words_packed (words_packed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          start;
        bit          en;
        bit          wr;
        bit          fr;
        bit          wv;
        logic [31:0] wo;
        int          wp;
    } vec_t;

    vec_t        tbl [25];
    logic [7:0]  src_q [$];
    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_words  = 0;
    bit          pend     = 1'b0;
    logic [7:0]  pend_byte;
    bit          hold     = 1'b0;
    logic [31:0] hold_wo;
    logic [31:0] last_word = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Starts at posedge+1, ends at the next posedge+1.
    task automatic step(input bit en, input bit wr, output bit fr, output bit wv,
                        output logic [31:0] wo, output logic [15:0] wp);
        logic [31:0] ew;
        bit          popped;
        fifo_valid = en && (src_q.size() > 0);
        word_ready = wr;
        #1;
        fr = fifo_ready;
        wv = word_valid;
        wo = word_out;
        wp = words_packed;
        if (hold) check("hold_stable", word_out, hold_wo);
        hold    = word_valid && !word_ready;
        hold_wo = word_out;
        if (word_valid && word_ready) begin
            if (exp_q.size() < 4) begin
                check("sb_underflow", exp_q.size(), 4);
            end else begin
                for (int k = 0; k < 4; k++) ew[k*8 +: 8] = exp_q.pop_front();
                check("sb_word", word_out, ew);
            end
            last_word = word_out;
            n_words++;
        end
        popped = fifo_valid && fifo_ready;
        if (popped) begin
            pend_byte = src_q.pop_front();
            exp_q.push_back(pend_byte);
        end
        @(posedge clk);
        #1;
        fifo_data = popped ? pend_byte : 8'($urandom);
        pend      = popped;
    endtask

    task automatic do_reset();
        #1 arst_in = 1'b1;
        #1;
        check("rst_fifo_ready", fifo_ready, 0);
        @(posedge clk);
        #1 arst_in = 1'b0;
        src_q.delete();
        exp_q.delete();
        pend    = 1'b0;
        hold    = 1'b0;
        n_words = 0;
    endtask

    bit          fr, wv;
    logic [31:0] wo;
    logic [15:0] wp;
    bit          done;

    initial begin
        tbl[0]  = '{1, 1, 1, 1, 0, 32'h0, 0};
        tbl[1]  = '{0, 1, 1, 1, 0, 32'h0, 0};
        tbl[2]  = '{0, 1, 1, 1, 0, 32'h0, 0};
        tbl[3]  = '{0, 1, 1, 1, 0, 32'h0, 0};
        tbl[4]  = '{0, 1, 1, 1, 0, 32'h0, 0};
        tbl[5]  = '{0, 1, 1, 1, 1, 32'h04030201, 1};
        tbl[6]  = '{0, 1, 1, 1, 0, 32'h04030201, 1};
        tbl[7]  = '{0, 1, 1, 1, 0, 32'h04030201, 1};
        tbl[8]  = '{0, 1, 1, 1, 0, 32'h04030201, 1};
        tbl[9]  = '{0, 1, 1, 1, 1, 32'h08070605, 2};
        tbl[10] = '{0, 1, 1, 1, 0, 32'h08070605, 2};
        tbl[11] = '{1, 1, 0, 1, 0, 32'h0, 0};
        tbl[12] = '{0, 1, 0, 1, 0, 32'h0, 0};
        tbl[13] = '{0, 1, 0, 1, 0, 32'h0, 0};
        tbl[14] = '{0, 1, 0, 1, 0, 32'h0, 0};
        tbl[15] = '{0, 1, 0, 1, 0, 32'h0, 0};
        tbl[16] = '{0, 1, 0, 1, 1, 32'h04030201, 1};
        tbl[17] = '{0, 1, 0, 1, 1, 32'h04030201, 1};
        tbl[18] = '{0, 1, 0, 1, 1, 32'h04030201, 1};
        tbl[19] = '{0, 1, 0, 0, 1, 32'h04030201, 1};
        tbl[20] = '{0, 1, 0, 0, 1, 32'h04030201, 1};
        tbl[21] = '{0, 1, 0, 0, 1, 32'h04030201, 1};
        tbl[22] = '{0, 1, 1, 0, 1, 32'h04030201, 1};
        tbl[23] = '{0, 1, 1, 1, 1, 32'h08070605, 2};
        tbl[24] = '{0, 1, 1, 1, 0, 32'h08070605, 2};

        arst_in    = 1'b1;
        fifo_valid = 1'b1;
        word_ready = 1'b1;
        fifo_data  = 8'h5A;
        #2;
        check("init_fifo_ready", fifo_ready, 0);
        check("init_word_valid", word_valid, 0);
        check("init_word_out", word_out, 0);
        check("init_words_packed", words_packed, 0);
        @(posedge clk);
        #1 arst_in = 1'b0;

        // Streaming and backpressure, cycle by cycle.
        for (int i = 0; i < 25; i++) begin
            if (tbl[i].start) begin
                do_reset();
                for (int b = 1; b <= 8; b++) src_q.push_back(8'(b));
            end
            step(tbl[i].en, tbl[i].wr, fr, wv, wo, wp);
            check($sformatf("vec%0d_fifo_ready", i), fr, tbl[i].fr);
            check($sformatf("vec%0d_word_valid", i), wv, tbl[i].wv);
            check($sformatf("vec%0d_word_out", i), wo, tbl[i].wo);
            check($sformatf("vec%0d_words_packed", i), wp, 16'(tbl[i].wp));
        end
        check("bp_sb_drained", exp_q.size(), 0);

        // Sparse input: fifo_valid every other cycle, junk on fifo_data otherwise.
        do_reset();
        for (int b = 0; b < 4; b++) src_q.push_back(8'hA0 + 8'(b));
        for (int c = 0; c < 30 && n_words == 0; c++) step(c % 2 == 0, 1'b1, fr, wv, wo, wp);
        check("sparse_word", last_word, 32'hA3A2A1A0);
        check("sparse_words_packed", words_packed, 1);
        check("sparse_sb_drained", exp_q.size(), 0);

        // Reset with a held word, two landed bytes and one byte in flight.
        do_reset();
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hEE, 8'hEE, 8'hEE};
        for (int c = 0; c < 7; c++) step(1'b1, 1'b0, fr, wv, wo, wp);
        fifo_valid = 1'b0;
        #1;
        check("midrst_pre_word_valid", word_valid, 1);
        check("midrst_pre_word_out", word_out, 32'h04030201);
        #2 arst_in = 1'b1;
        #1;
        check("midrst_word_valid", word_valid, 0);
        check("midrst_word_out", word_out, 0);
        check("midrst_words_packed", words_packed, 0);
        check("midrst_fifo_ready", fifo_ready, 0);
        @(posedge clk);
        #1;
        check("midrst_hold_fifo_ready", fifo_ready, 0);
        arst_in = 1'b0;
        src_q.delete();
        exp_q.delete();
        pend    = 1'b0;
        hold    = 1'b0;
        n_words = 0;
        for (int b = 0; b < 4; b++) src_q.push_back(8'h11 + 8'(b));
        for (int c = 0; c < 30 && n_words == 0; c++) step(1'b1, 1'b1, fr, wv, wo, wp);
        check("midrst_word", last_word, 32'h14131211);
        check("midrst_words_packed_after", words_packed, 1);

        // Random valid/ready over 10k bytes.
        do_reset();
        for (int b = 0; b < 10000; b++) src_q.push_back(8'($urandom));
        done = 1'b0;
        for (int c = 0; c < 80000 && !done; c++) begin
            if (src_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
            else if (src_q.size() == 0) step(1'b0, 1'b1, fr, wv, wo, wp);
            else step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, fr, wv, wo, wp);
        end
        check("random_completed", done, 1);
        check("random_word_count", n_words, 2500);
        #1;
        check("random_words_packed", words_packed, 16'(2500));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
